// File: rtl/core_pkg.sv
// Shared core definitions: ResultSrc encodings, ALU control width and the
// packed EX-stage control word.
package core_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_e;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_write;
        logic                  alu_src;
        logic                  branch;
        logic                  jump;
        logic                  valid;
        logic [1:0]            result_src;
        logic [ALU_CTRL_W-1:0] alu_control;
    } ctrl_e_t;

    // A bubble keeps ALU select bits but can never write, branch or jump.
    function automatic ctrl_e_t make_bubble(input ctrl_e_t c);
        ctrl_e_t b;
        b            = c;
        b.reg_write  = 1'b0;
        b.mem_write  = 1'b0;
        b.branch     = 1'b0;
        b.jump       = 1'b0;
        b.valid      = 1'b0;
        b.result_src = 2'b00;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use stall and branch/jump flush generation for the
// IF/ID and ID/EX pipeline registers.
module hazard_detect
    import core_pkg::*;
#(
    parameter int RADDR = 5
) (
    input  logic             ValidE,
    input  logic [1:0]       ResultSrcE,
    input  logic [RADDR-1:0] RdE,
    input  logic [RADDR-1:0] Rs1D,
    input  logic [RADDR-1:0] Rs2D,
    input  logic             PCSrcE,
    output logic             lu,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             flushE
);

    logic is_load_e;
    logic rd_match;

    assign is_load_e = ValidE && (ResultSrcE == RES_MEM);
    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign rd_match  = (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign lu        = is_load_e && rd_match;

    // A taken redirect squashes the consumer anyway, so it overrides the stall.
    assign StallF = lu && !PCSrcE;
    assign StallD = lu && !PCSrcE;
    assign FlushD = PCSrcE;
    assign flushE = lu || PCSrcE;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch/jump flush and redirect.
// Optional HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt event counters.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteD,
    input  logic                  MemWriteD,
    input  logic                  ALUSrcD,
    input  logic                  BranchD,
    input  logic                  JumpD,
    input  logic [1:0]            ResultSrcD,
    input  logic [ALU_CTRL_W-1:0] ALUControlD,
    input  logic [RADDR-1:0]      Rs1D,
    input  logic [RADDR-1:0]      Rs2D,
    input  logic [RADDR-1:0]      RdD,
    input  logic [XLEN-1:0]       RD1D,
    input  logic [XLEN-1:0]       RD2D,
    input  logic [XLEN-1:0]       ImmExtD,
    input  logic [XLEN-1:0]       PCD,
    input  logic [XLEN-1:0]       PCPlus4D,
    input  logic                  ZeroE,
    input  logic [XLEN-1:0]       PCTargetE,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  ALUSrcE,
    output logic                  BranchE,
    output logic                  JumpE,
    output logic                  ValidE,
    output logic [1:0]            ResultSrcE,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic [RADDR-1:0]      Rs1E,
    output logic [RADDR-1:0]      Rs2E,
    output logic [RADDR-1:0]      RdE,
    output logic [XLEN-1:0]       RD1E,
    output logic [XLEN-1:0]       RD2E,
    output logic [XLEN-1:0]       ImmExtE,
    output logic [XLEN-1:0]       PCE,
    output logic [XLEN-1:0]       PCPlus4E,
    output logic                  PCSrcE,
    output logic [XLEN-1:0]       PCNextSel,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    ctrl_e_t          ctrl_p0;
    ctrl_e_t          ctrl_p1;
    logic [RADDR-1:0] rs1_p1, rs2_p1, rd_p1;
    logic [XLEN-1:0]  rd1_p1, rd2_p1, imm_p1, pc_p1, pcp4_p1;
    logic             lu;
    logic             flushE;

    assign ctrl_p0 = '{
        reg_write:   RegWriteD,
        mem_write:   MemWriteD,
        alu_src:     ALUSrcD,
        branch:      BranchD,
        jump:        JumpD,
        valid:       1'b1,
        result_src:  ResultSrcD,
        alu_control: ALUControlD
    };

    hazard_detect #(
        .RADDR (RADDR)
    ) u_hazard (
        .ValidE     (ctrl_p1.valid),
        .ResultSrcE (ctrl_p1.result_src),
        .RdE        (rd_p1),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .PCSrcE     (PCSrcE),
        .lu         (lu),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .flushE     (flushE)
    );

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_p1 <= '0;
        end else if (flushE) begin
            ctrl_p1 <= make_bubble(ctrl_p0);
        end else begin
            ctrl_p1 <= ctrl_p0;
        end
    end

    // Operands hold during a load-use bubble; the consumer re-presents them next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_p1  <= '0;
            rs2_p1  <= '0;
            rd_p1   <= '0;
            rd1_p1  <= '0;
            rd2_p1  <= '0;
            imm_p1  <= '0;
            pc_p1   <= '0;
            pcp4_p1 <= '0;
        end else if (!lu) begin
            rs1_p1  <= Rs1D;
            rs2_p1  <= Rs2D;
            rd_p1   <= RdD;
            rd1_p1  <= RD1D;
            rd2_p1  <= RD2D;
            imm_p1  <= ImmExtD;
            pc_p1   <= PCD;
            pcp4_p1 <= PCPlus4D;
        end
    end

    // ---- EX stage outputs ----
    assign RegWriteE   = ctrl_p1.reg_write;
    assign MemWriteE   = ctrl_p1.mem_write;
    assign ALUSrcE     = ctrl_p1.alu_src;
    assign BranchE     = ctrl_p1.branch;
    assign JumpE       = ctrl_p1.jump;
    assign ValidE      = ctrl_p1.valid;
    assign ResultSrcE  = ctrl_p1.result_src;
    assign ALUControlE = ctrl_p1.alu_control;
    assign Rs1E        = rs1_p1;
    assign Rs2E        = rs2_p1;
    assign RdE         = rd_p1;
    assign RD1E        = rd1_p1;
    assign RD2E        = rd2_p1;
    assign ImmExtE     = imm_p1;
    assign PCE         = pc_p1;
    assign PCPlus4E    = pcp4_p1;

    assign PCSrcE    = ctrl_p1.valid && ((ctrl_p1.branch && ZeroE) || ctrl_p1.jump);
    assign PCNextSel = PCTargetE;

`ifdef HAZARD_PERF_CNT_EN
    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallD) stall_cnt <= stall_cnt + 32'd1;
            if (FlushD) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage; counter checks need HAZARD_PERF_CNT_EN.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int RADDR = 5;

    typedef struct packed {
        logic        vld, rw, mw, as, br, jp;
        logic [1:0]  rs;
        logic [3:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm, pc, pcp4;
    } erec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD;
    logic [1:0] ResultSrcD;
    logic [3:0] ALUControlD;
    logic [RADDR-1:0] Rs1D, Rs2D, RdD;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic ZeroE;
    logic [XLEN-1:0] PCTargetE;
    logic RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ValidE;
    logic [1:0] ResultSrcE;
    logic [3:0] ALUControlE;
    logic [RADDR-1:0] Rs1E, Rs2E, RdE;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic PCSrcE;
    logic [XLEN-1:0] PCNextSel;
    logic StallF, StallD, FlushD;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    id_ex_stage #(.XLEN(XLEN), .RADDR(RADDR)) dut (
        .clk(clk), .rst(rst),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
        .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
        .ALUControlD(ALUControlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ZeroE(ZeroE), .PCTargetE(PCTargetE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .ValidE(ValidE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .PCSrcE(PCSrcE), .PCNextSel(PCNextSel),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    int    vectors = 0;
    int    miscompares = 0;
    erec_t sb[$];
    bit    full_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic rw, mw, as, br, jp, input logic [1:0] rs,
                         input logic [3:0] alu, input logic [4:0] r1, r2, rd);
        logic [31:0] pc;
        RegWriteD = rw; MemWriteD = mw; ALUSrcD = as; BranchD = br; JumpD = jp;
        ResultSrcD = rs; ALUControlD = alu; Rs1D = r1; Rs2D = r2; RdD = rd;
        RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
        pc = $urandom;
        PCD = pc & 32'hFFFF_FFFC;
        PCPlus4D = PCD + 32'd4;
    endtask

    function automatic erec_t d_rec();
        erec_t e;
        e = '{vld: 1'b1, rw: RegWriteD, mw: MemWriteD, as: ALUSrcD, br: BranchD,
              jp: JumpD, rs: ResultSrcD, alu: ALUControlD, rs1: Rs1D, rs2: Rs2D,
              rd: RdD, rd1: RD1D, rd2: RD2D, imm: ImmExtD, pc: PCD, pcp4: PCPlus4D};
        return e;
    endfunction

    // kind: 0 = reset state (all zero), 1 = D fields captured, 2 = bubble
    task automatic step(input string tag, input bit do_comb, input bit e_stall,
                        input bit e_flush, input int kind);
        erec_t e;
        bit    full;
        #1;
        if (do_comb) begin
            chk({tag, ".StallF"}, 32'(StallF), 32'(e_stall));
            chk({tag, ".StallD"}, 32'(StallD), 32'(e_stall));
            chk({tag, ".FlushD"}, 32'(FlushD), 32'(e_flush));
            chk({tag, ".PCSrcE"}, 32'(PCSrcE), 32'(e_flush));
        end
        e = (kind == 1) ? d_rec() : '0;
        sb.push_back(e);
        full_q.push_back(kind != 2);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        full = full_q.pop_front();
        chk({tag, ".ctrl"}, 32'({ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE}),
            32'({e.vld, e.rw, e.mw, e.br, e.jp, e.rs}));
        if (full) begin
            chk({tag, ".sel"}, 32'({ALUSrcE, ALUControlE}), 32'({e.as, e.alu}));
            chk({tag, ".regs"}, 32'({Rs1E, Rs2E, RdE}), 32'({e.rs1, e.rs2, e.rd}));
            chk({tag, ".RD1E"}, RD1E, e.rd1);
            chk({tag, ".RD2E"}, RD2E, e.rd2);
            chk({tag, ".ImmExtE"}, ImmExtE, e.imm);
            chk({tag, ".PCE"}, PCE, e.pc);
            chk({tag, ".PCPlus4E"}, PCPlus4E, e.pcp4);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ZeroE = 1'b1;
        PCTargetE = 32'h100;
        set_d(1, 1, 1, 1, 1, 2'b01, 4'hF, 5'd31, 5'd31, 5'd31);
        @(negedge clk);
        step("rst0", 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0);

        rst = 1'b0;
        ZeroE = 1'b0;
        set_d(1, 0, 1, 0, 0, 2'b01, 4'h0, 5'd2, 5'd0, 5'd5);   // lw x5
        step("lw", 1, 0, 0, 1);
        set_d(1, 0, 0, 0, 0, 2'b00, 4'h0, 5'd5, 5'd6, 5'd7);   // add x7,x5,x6
        step("lu_rs1", 1, 1, 0, 2);
        step("add_ex", 1, 0, 0, 1);
        chk("add_ex.Rs1E", 32'(Rs1E), 32'd5);

        set_d(1, 0, 1, 0, 0, 2'b01, 4'h0, 5'd3, 5'd0, 5'd0);   // load to x0
        step("ld_x0", 1, 0, 0, 1);
        set_d(1, 0, 0, 0, 0, 2'b00, 4'h1, 5'd1, 5'd0, 5'd8);
        step("x0_exempt", 1, 0, 0, 1);

        set_d(0, 0, 0, 1, 0, 2'b00, 4'h2, 5'd1, 5'd2, 5'd0);   // beq
        step("beq", 1, 0, 0, 1);
        ZeroE = 1'b1;
        set_d(1, 0, 0, 0, 0, 2'b00, 4'h0, 5'd9, 5'd9, 5'd9);
        #1 chk("br_taken.PCNextSel", PCNextSel, 32'h100);
        step("br_taken", 1, 0, 1, 2);
        set_d(0, 0, 0, 1, 0, 2'b00, 4'h2, 5'd1, 5'd2, 5'd0);
        step("br_after", 1, 0, 0, 1);
        ZeroE = 1'b0;
        set_d(1, 0, 0, 0, 0, 2'b00, 4'h3, 5'd4, 5'd4, 5'd10);
        step("br_not_taken", 1, 0, 0, 1);

        set_d(1, 0, 0, 0, 1, 2'b01, 4'h0, 5'd0, 5'd0, 5'd5);   // jump also flagged as load
        step("jl", 1, 0, 0, 1);
        set_d(1, 0, 0, 0, 0, 2'b00, 4'h0, 5'd5, 5'd1, 5'd11);
        step("lu_jump", 1, 0, 1, 2);
        step("after_sim", 1, 0, 0, 1);

        set_d(1, 0, 0, 0, 0, 2'b01, 4'h0, 5'd0, 5'd0, 5'd12);  // lw x12
        step("lw2", 1, 0, 0, 1);
        set_d(1, 0, 0, 0, 0, 2'b00, 4'h0, 5'd1, 5'd12, 5'd13);
        rst = 1'b1;
        step("rst_mid", 1, 1, 0, 0);
        rst = 1'b0;
        step("post_rst", 1, 0, 0, 1);

`ifdef HAZARD_PERF_CNT_EN
        for (int i = 0; i < 3; i++) begin
            set_d(1, 0, 1, 0, 0, 2'b01, 4'h0, 5'd2, 5'd0, 5'd5);
            step("pc_lw", 1, 0, 0, 1);
            set_d(1, 0, 0, 0, 0, 2'b00, 4'h0, 5'd5, 5'd3, 5'd6);
            step("pc_stall", 1, 1, 0, 2);
            step("pc_use", 1, 0, 0, 1);
        end
        for (int i = 0; i < 2; i++) begin
            set_d(1, 0, 0, 0, 1, 2'b10, 4'h0, 5'd0, 5'd0, 5'd1);
            step("pc_jal", 1, 0, 0, 1);
            set_d(1, 0, 0, 0, 0, 2'b00, 4'h0, 5'd7, 5'd7, 5'd7);
            step("pc_flush", 1, 0, 1, 2);
            step("pc_next", 1, 0, 0, 1);
        end
        chk("stall_cnt", stall_cnt, 32'd3);
        chk("flush_cnt", flush_cnt, 32'd2);
        force dut.flush_cnt = 32'hFFFF_FFFF;
        #1 release dut.flush_cnt;
        set_d(1, 0, 0, 0, 1, 2'b10, 4'h0, 5'd0, 5'd0, 5'd1);
        step("wrap_jal", 1, 0, 0, 1);
        set_d(1, 0, 0, 0, 0, 2'b00, 4'h0, 5'd7, 5'd7, 5'd7);
        step("wrap_flush", 1, 0, 1, 2);
        chk("flush_cnt_wrap", flush_cnt, 32'd0);
        chk("stall_cnt_hold", stall_cnt, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage RISC-V core, directly downstream of the control unit: registers the decoded control word and operand fields into the Execute stage. It owns the load-use stall and the branch/jump flush, resolving taken control transfers from the EX-stage branch/jump bits and the ALU zero flag. It drives the stall/flush controls for the IF and ID registers and inserts bubbles into EX.

## Interface
Parameters:
- XLEN, 32, datapath width for PC, immediate and register operands.
- RADDR, 5, register-index width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD  in  1 each  control bits from the control unit.
- ResultSrcD  in  2  result select: 00 ALU, 01 memory (load), 10 PC+4.
- ALUControlD  in  4  ALU operation.
- Rs1D, Rs2D, RdD  in  RADDR each  register indices of the ID instruction.
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each  operands and PCs.
- ZeroE  in  1  ALU zero flag for the instruction currently in EX.
- PCTargetE  in  XLEN  branch/jump target computed in EX.
- RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ValidE  out  1 each  registered EX control bits.
- ResultSrcE  out  2;  ALUControlE  out  4;  Rs1E, Rs2E, RdE  out  RADDR;  RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN.
- PCSrcE  out  1  taken redirect: (BranchE & ZeroE) | JumpE, gated by ValidE; combinational.
- PCNextSel  out  XLEN  PCTargetE when PCSrcE, else don't-care (passes PCTargetE).
- StallF, StallD  out  1  hold PC and IF/ID register; combinational.
- FlushD  out  1  clear IF/ID register; combinational.

## Operation
- Load-use hazard: lu = ValidE & (ResultSrcE == 01) & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
- StallF = StallD = lu & ~PCSrcE.
- FlushD = PCSrcE.
- Bubble condition: flushE = lu | PCSrcE.
- Register update each cycle:
  - rst: all outputs 0.
  - flushE: control bits (RegWrite, MemWrite, Branch, Jump, Valid) and ResultSrc cleared to 0. Data fields may load or hold; they are ignored when ValidE = 0.
  - Otherwise: all D fields captured and ValidE <= 1.
- A bubble must never write the register file or memory, and must never assert PCSrcE.
- Register x0: a load to rd = 0 never stalls.

## Timing
- Latency: one cycle, D inputs to E outputs.
- Reset: every registered output is 0 on the first edge with rst = 1, including ValidE. PCSrcE, StallF, StallD and FlushD are 0 while ValidE = 0.
- Load-use:
  - Exactly one bubble per load-use pair.
  - The cycle after a stall, the load has left EX, so lu deasserts and the consumer enters EX.
- Branch/jump taken in EX:
  - FlushD and flushE assert in the same cycle.
  - Two wrong-path instructions are squashed (IF/ID and the one entering EX).
- Simultaneous lu and PCSrcE: flush wins. No stall, the consumer is squashed, and the PC redirects.
- rst asserted mid-stall or mid-flush: the next state is the reset state. The outstanding hazard is dropped.

## Configuration
- HAZARD_PERF_CNT_EN defined adds the following outputs:
  - stall_cnt, 32-bit: increments on each cycle with StallD = 1.
  - flush_cnt, 32-bit: increments on each cycle with FlushD = 1.
  - Both counters wrap modulo 2^32, reset to 0, and never saturate.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package core_pkg holds:
  - ResultSrc encodings RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10.
  - The ALUControl width constant.
  - A packed ctrl_e_t struct of the EX control bits.
- One sub-module, hazard_detect: purely combinational. It produces lu, StallF, StallD, FlushD and flushE from ValidE, ResultSrcE, RdE, Rs1D, Rs2D and PCSrcE.
- The pipeline register itself lives in id_ex_stage.

## Test plan
- Reset: drive all D inputs nonzero with rst = 1 for 2 cycles. Expect all E outputs = 0, ValidE = 0 and PCSrcE = 0.
- Load-use, rs1 conflict: lw x5 in EX (ResultSrcE = 01, RdE = 5); add with Rs1D = 5 in ID.
  - Expect StallF = StallD = 1 for one cycle, then a bubble in EX (ValidE = 0, RegWriteE = 0).
  - The next cycle, add is in EX with Rs1E = 5.
- x0 exemption: load with RdE = 0 and Rs2D = 0. Expect no stall and no bubble.
- Taken branch: BranchE = 1, ZeroE = 1, PCTargetE = 0x100.
  - Expect PCSrcE = 1, FlushD = 1 and PCNextSel = 0x100.
  - The next cycle, ValidE = 0.
  - Repeat with ZeroE = 0: expect no flush.
- Simultaneous: load-use condition together with JumpE = 1. Expect StallD = 0, FlushD = 1 and a bubble in EX.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls and 2 jumps. Expect stall_cnt = 3 and flush_cnt = 2. Preload flush_cnt near 0xFFFFFFFF and check it wraps to 0.
